// File: rtl/text_glyph_writer.sv
// ============================================================================
// Module      : text_glyph_writer
// Description : Renders one 8x8 font glyph into a linear pixel framebuffer,
//               fetching rows from an external font ROM and clipping
//               off-screen pixels.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module text_glyph_writer #(
   parameter int H_RES       = 640,
   parameter int V_RES       = 480,
   parameter int FB_AW       = 19,
   parameter int COLOR_W     = 8,
   parameter int TRANSPARENT = 0
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [15:0]        text_x,
   input  logic [15:0]        text_y,
   input  logic [7:0]         text_char,
   input  logic [COLOR_W-1:0] text_fg,
   input  logic [COLOR_W-1:0] text_bg,
   input  logic               text_go,
   output logic               busy,
   output logic               done,
   output logic [10:0]        font_addr,
   input  logic [7:0]         font_data,
   output logic [FB_AW-1:0]   fb_addr,
   output logic [COLOR_W-1:0] fb_data,
   output logic               fb_we,
   input  logic               fb_ready
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_DRAW  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [16:0]      c_H_RES    = 17'(H_RES);
   localparam logic [16:0]      c_V_RES    = 17'(V_RES);
   localparam logic [FB_AW-1:0] c_H_RES_A  = FB_AW'(H_RES);
   localparam logic             c_TRANSP   = (TRANSPARENT != 0);

   state_t               r_state;
   state_t               w_next;
   logic                 r_go_q;
   logic                 r_done;
   logic [15:0]          r_x;
   logic [15:0]          r_y;
   logic [7:0]           r_char;
   logic [COLOR_W-1:0]   r_fg;
   logic [COLOR_W-1:0]   r_bg;
   logic [2:0]           r_row;
   logic [2:0]           r_col;
   logic [7:0]           r_bits;

   logic                 w_trigger;
   logic [16:0]          w_px;
   logic [16:0]          w_py;
   logic                 w_bit;
   logic                 w_clip;
   logic                 w_skip;
   logic                 w_advance;
   logic [FB_AW-1:0]     w_lin;

   assign w_trigger = text_go && !r_go_q;

   // Pixel coordinates are widened to 17 bits so x/y near 0xFFFF cannot wrap on-screen.
   assign w_px   = {1'b0, r_x} + {14'd0, r_col};
   assign w_py   = {1'b0, r_y} + {14'd0, r_row};
   assign w_bit  = r_bits[3'd7 - r_col];
   assign w_clip = (w_px >= c_H_RES) || (w_py >= c_V_RES);
   assign w_skip = w_clip || (c_TRANSP && !w_bit);
   assign w_lin  = (FB_AW'(w_py) * c_H_RES_A) + FB_AW'(w_px);

   assign busy      = (r_state != S_IDLE);
   assign done      = r_done;
   assign font_addr = {r_char, r_row};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      fb_we     = 1'b0;
      fb_addr   = '0;
      fb_data   = '0;
      w_advance = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_trigger) begin
               w_next = S_FETCH;
            end
         end
         S_FETCH: begin
            w_next = S_WAIT;
         end
         S_WAIT: begin
            w_next = S_DRAW;
         end
         S_DRAW: begin
            if (!w_skip) begin
               fb_we   = 1'b1;
               fb_addr = w_lin;
               fb_data = w_bit ? r_fg : r_bg;
            end
            w_advance = w_skip || fb_ready;
            if (w_advance && (r_col == 3'd7)) begin
               w_next = (r_row == 3'd7) ? S_DONE : S_FETCH;
            end
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // go_q resets high so a command level already asserted at reset release is not an edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_go_q <= 1'b1;
         r_done <= 1'b0;
         r_x    <= '0;
         r_y    <= '0;
         r_char <= '0;
         r_fg   <= '0;
         r_bg   <= '0;
         r_row  <= '0;
         r_col  <= '0;
         r_bits <= '0;
      end else begin
         r_go_q <= text_go;
         r_done <= (w_next == S_DONE);
         case (r_state)
            S_IDLE: begin
               if (w_trigger) begin
                  r_x    <= text_x;
                  r_y    <= text_y;
                  r_char <= text_char;
                  r_fg   <= text_fg;
                  r_bg   <= text_bg;
                  r_row  <= 3'd0;
                  r_col  <= 3'd0;
               end
            end
            S_WAIT: begin
               r_bits <= font_data;
            end
            S_DRAW: begin
               if (w_advance) begin
                  r_col <= r_col + 3'd1;
                  if ((r_col == 3'd7) && (r_row != 3'd7)) begin
                     r_row <= r_row + 3'd1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_text_glyph_writer.sv
// Scoreboard bench for text_glyph_writer: an opaque and a transparent instance
// share all stimulus; expected pixel writes are queued per instance.
`default_nettype none

module tb_text_glyph_writer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] text_x = '0;
   logic [15:0] text_y = '0;
   logic [7:0]  text_char = '0;
   logic [7:0]  text_fg = '0;
   logic [7:0]  text_bg = '0;
   logic        text_go = 1'b1;
   logic        fb_ready = 1'b1;
   logic        bp_mode = 1'b0;

   logic        busy0, done0, fb_we0, busy1, done1, fb_we1;
   logic [10:0] font_addr0, font_addr1;
   logic [7:0]  fd0, fd1, fb_data0, fb_data1;
   logic [18:0] fb_addr0, fb_addr1;

   logic [7:0]  rom [0:2047];

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int wr0 = 0, wr1 = 0, base0 = 0, base1 = 0;
   int exp0 = 0, exp1 = 0;
   int stalls0 = 0;
   int t_drive = 0;
   int last_done1 = 0;
   int last_addr0 = 0;
   int q0a[$], q0d[$], q1a[$], q1d[$];
   bit prev_stall0 = 1'b0;
   logic [18:0] prev_a0;
   logic [7:0]  prev_d0;

   text_glyph_writer #(.TRANSPARENT(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .text_x(text_x), .text_y(text_y),
      .text_char(text_char), .text_fg(text_fg), .text_bg(text_bg), .text_go(text_go),
      .busy(busy0), .done(done0), .font_addr(font_addr0), .font_data(fd0),
      .fb_addr(fb_addr0), .fb_data(fb_data0), .fb_we(fb_we0), .fb_ready(fb_ready)
   );

   text_glyph_writer #(.TRANSPARENT(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .text_x(text_x), .text_y(text_y),
      .text_char(text_char), .text_fg(text_fg), .text_bg(text_bg), .text_go(text_go),
      .busy(busy1), .done(done1), .font_addr(font_addr1), .font_data(fd1),
      .fb_addr(fb_addr1), .fb_data(fb_data1), .fb_we(fb_we1), .fb_ready(fb_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      fd0 <= rom[font_addr0];
      fd1 <= rom[font_addr1];
   end

   initial begin
      for (int i = 0; i < 2048; i++) rom[i] = 8'h00;
      rom[{8'h41, 3'd0}] = 8'h18;
      rom[{8'h41, 3'd1}] = 8'h24;
      rom[{8'h41, 3'd2}] = 8'h42;
      rom[{8'h41, 3'd3}] = 8'h7E;
      rom[{8'h41, 3'd4}] = 8'h42;
      rom[{8'h41, 3'd5}] = 8'h42;
      rom[{8'h41, 3'd6}] = 8'h42;
      rom[{8'h41, 3'd7}] = 8'h00;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // Ready is either held high or toggled every cycle.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         fb_ready = bp_mode ? ~fb_ready : 1'b1;
      end
   end

   // Output monitor: pops expected writes as the sink accepts them.
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_stall0 = 1'b0;
      end else begin
         if (prev_stall0) begin
            check("stall_we", fb_we0, 1);
            check("stall_addr", fb_addr0, prev_a0);
            check("stall_data", fb_data0, prev_d0);
         end
         prev_stall0 = fb_we0 && !fb_ready;
         prev_a0 = fb_addr0;
         prev_d0 = fb_data0;
         if (fb_we0 && !fb_ready) stalls0++;
         if (fb_we0 && fb_ready) begin
            wr0++;
            last_addr0 = int'(fb_addr0);
            check("addr_range0", fb_addr0 < 19'd307200, 1);
            check("wr0_expected", q0a.size() != 0, 1);
            if (q0a.size() != 0) begin
               check("wr0_addr", fb_addr0, q0a.pop_front());
               check("wr0_data", fb_data0, q0d.pop_front());
            end
         end
         if (fb_we1 && fb_ready) begin
            wr1++;
            check("wr1_expected", q1a.size() != 0, 1);
            if (q1a.size() != 0) begin
               check("wr1_addr", fb_addr1, q1a.pop_front());
               check("wr1_data", fb_data1, q1d.pop_front());
            end
         end
         if (done1) last_done1 = cyc;
      end
   end

   task automatic model_push(input int x, input int y, input logic [7:0] ch,
                             input logic [7:0] fg, input logic [7:0] bg);
      logic [7:0] bits;
      logic [10:0] a;
      int px, py;
      exp0 = 0;
      exp1 = 0;
      for (int r = 0; r < 8; r++) begin
         a = {ch, 3'(r)};
         bits = rom[a];
         for (int c = 0; c < 8; c++) begin
            px = x + c;
            py = y + r;
            if (px < 640 && py < 480) begin
               q0a.push_back(py * 640 + px);
               q0d.push_back(bits[7-c] ? int'(fg) : int'(bg));
               exp0++;
               if (bits[7-c]) begin
                  q1a.push_back(py * 640 + px);
                  q1d.push_back(int'(fg));
                  exp1++;
               end
            end
         end
      end
   endtask

   task automatic start_glyph(input int x, input int y, input logic [7:0] ch,
                              input logic [7:0] fg, input logic [7:0] bg);
      text_go = 1'b0;
      @(posedge clk);
      #1;
      text_x = 16'(x);
      text_y = 16'(y);
      text_char = ch;
      text_fg = fg;
      text_bg = bg;
      model_push(x, y, ch, fg, bg);
      base0 = wr0;
      base1 = wr1;
      stalls0 = 0;
      text_go = 1'b1;
      t_drive = cyc;
   endtask

   task automatic finish_glyph(input string tag, input int exp_lat, input bit add_stalls,
                               input bit chk_lat1);
      bit seen = 1'b0;
      bit idle = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (done0) begin
            seen = 1'b1;
            break;
         end
      end
      check({tag, "_done_seen"}, seen, 1);
      if (seen) check({tag, "_done_lat"}, cyc - t_drive, exp_lat + (add_stalls ? stalls0 : 0));
      @(negedge clk);
      check({tag, "_busy_after"}, busy0, 0);
      check({tag, "_done_pulse"}, done0, 0);
      for (int i = 0; i < 2000; i++) begin
         if (!busy0 && !busy1) begin
            idle = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check({tag, "_idle"}, idle, 1);
      if (chk_lat1) check({tag, "_done1_lat"}, last_done1 - t_drive, exp_lat);
      check({tag, "_writes0"}, wr0 - base0, exp0);
      check({tag, "_writes1"}, wr1 - base1, exp1);
      check({tag, "_q0_left"}, q0a.size(), 0);
      check({tag, "_q1_left"}, q1a.size(), 0);
   endtask

   initial begin
      // Reset with the command level already high.
      reset_n = 1'b0;
      text_go = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy0, 0);
      check("rst_done", done0, 0);
      check("rst_we", fb_we0, 0);
      check("rst_addr", fb_addr0, 0);
      check("rst_data", fb_data0, 0);
      check("rst_font_addr", font_addr0, 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("go_high_release_busy", busy0, 0);
      check("go_high_release_writes", wr0, 0);

      // Basic and transparent glyph, with a retrigger while busy.
      start_glyph(100, 50, 8'h41, 8'hFF, 8'h00);
      @(posedge clk);
      @(negedge clk);
      check("t1_busy", busy0, 1);
      check("t1_font_addr", font_addr0, 11'h208);
      check("t1_we_fetch", fb_we0, 0);
      @(negedge clk);
      check("t2_we_wait", fb_we0, 0);
      @(negedge clk);
      check("t3_we", fb_we0, 1);
      check("t3_addr", fb_addr0, 32100);
      check("t3_data", fb_data0, 8'h00);
      @(posedge clk);
      #1;
      text_go = 1'b0;
      text_x = 16'd3;
      text_fg = 8'h33;
      repeat (2) @(posedge clk);
      #1;
      text_go = 1'b1;
      finish_glyph("basic", 81, 1'b0, 1'b1);

      // Bottom-right clipping.
      start_glyph(636, 476, 8'h41, 8'hC3, 8'h3C);
      finish_glyph("clip", 81, 1'b0, 1'b1);
      check("clip_last_addr", last_addr0, 307199);

      // Backpressure: ready toggles each cycle.
      bp_mode = 1'b1;
      start_glyph(10, 20, 8'h41, 8'h5A, 8'hA5);
      finish_glyph("bp", 81, 1'b1, 1'b0);
      check("bp_stalls_seen", stalls0 > 0, 1);
      bp_mode = 1'b0;

      // Reset during row 3 abandons the glyph.
      start_glyph(200, 100, 8'h41, 8'hFF, 8'h11);
      repeat (35) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("midrst_we", fb_we0, 0);
      check("midrst_busy", busy0, 0);
      check("midrst_done", done0, 0);
      check("midrst_busy1", busy1, 0);
      q0a.delete();
      q0d.delete();
      q1a.delete();
      q1d.delete();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      base0 = wr0;
      repeat (100) @(posedge clk);
      #1;
      check("postrst_writes", wr0 - base0, 0);
      check("postrst_busy", busy0, 0);

      start_glyph(0, 0, 8'h41, 8'h0F, 8'hF0);
      finish_glyph("after_rst", 81, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
